// File: rtl/color_freq_sampler.sv
// color_freq_sampler
//
// Purpose: steps a TCS3200-style light-to-frequency sensor through its red,
// green and blue filters. For each filter it waits a settle time and then
// counts rising edges of the sensor output over a fixed gate window. After
// the blue window it publishes all three counts and a dominant-colour code.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   en          run enable; frames repeat back-to-back while high
//   sensor_out  sensor frequency output, asynchronous to clk
//   s2, s3      filter select to sensor: red 00, green 11, blue 01
//   red_cnt     last published red count
//   green_cnt   last published green count
//   blue_cnt    last published blue count
//   color       00 none/ambiguous, 01 red, 10 green, 11 blue
//   valid       one-cycle pulse when a new frame is published
//   busy        high while a frame is in progress
module color_freq_sampler #(
  parameter int unsigned GATE_CYCLES   = 1_000_000,
  parameter int unsigned SETTLE_CYCLES = 10_000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_COUNT     = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sensor_out,
  output logic             s2,
  output logic             s3,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [1:0]       color,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_GATE     = 2'd2,
    ST_CLASSIFY = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);
  localparam logic [31:0]      SETTLE_LAST = SETTLE_CYCLES - 32'd1;
  localparam logic [31:0]      GATE_LAST   = GATE_CYCLES - 32'd1;

  // Winner must beat both other channels strictly and reach the threshold,
  // so any tie for first place yields "none".
  function automatic logic [1:0] pick_color(input logic [CNT_W-1:0] r,
                                            input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
    logic [1:0] c;
    c = 2'b00;
    if ((r > g) && (r > b) && (r >= MIN_CNT)) begin
      c = 2'b01;
    end else if ((g > r) && (g > b) && (g >= MIN_CNT)) begin
      c = 2'b10;
    end else if ((b > r) && (b > g) && (b >= MIN_CNT)) begin
      c = 2'b11;
    end else begin
      c = 2'b00;
    end
    return c;
  endfunction

  // Filter pin encoding for a channel; clear (10) is never produced.
  function automatic logic [1:0] filt_of(input chan_e ch);
    logic [1:0] f;
    case (ch)
      CH_R:    f = 2'b00;
      CH_G:    f = 2'b11;
      CH_B:    f = 2'b01;
      default: f = 2'b00;
    endcase
    return f;
  endfunction

  state_e           state_q, state_d;
  chan_e            ch_q, ch_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] shad_r_q, shad_r_d;
  logic [CNT_W-1:0] shad_g_q, shad_g_d;
  logic [CNT_W-1:0] red_q, red_d;
  logic [CNT_W-1:0] green_q, green_d;
  logic [CNT_W-1:0] blue_q, blue_d;
  logic [1:0]       color_q, color_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [1:0]       filt_q, filt_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             edge_s;
  logic [CNT_W-1:0] edge_inc_s;

  // Two-flop synchroniser plus a third copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sensor_out;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_s = sync2_q & ~sync3_q;

  // Saturating increment of the edge counter.
  always_comb begin
    edge_inc_s = edge_cnt_q;
    if (edge_s && (edge_cnt_q != CNT_MAX)) begin
      edge_inc_s = edge_cnt_q + CNT_W'(1);
    end else begin
      edge_inc_s = edge_cnt_q;
    end
  end

  // Next-state logic for the frame sequencer and the published outputs.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cyc_d      = cyc_q;
    edge_cnt_d = edge_cnt_q;
    shad_r_d   = shad_r_q;
    shad_g_d   = shad_g_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    color_d    = color_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_SETTLE;
          ch_d       = CH_R;
          cyc_d      = 32'd0;
          edge_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        edge_cnt_d = {CNT_W{1'b0}};
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cyc_q == SETTLE_LAST) begin
          state_d = ST_GATE;
          cyc_d   = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end

      ST_GATE: begin
        if (!en) begin
          // Abort: partial shadow counts are simply never published.
          state_d = ST_IDLE;
        end else if (cyc_q == GATE_LAST) begin
          // An edge seen in this final gate cycle is still included.
          cyc_d      = 32'd0;
          edge_cnt_d = {CNT_W{1'b0}};
          case (ch_q)
            CH_R: begin
              shad_r_d = edge_inc_s;
              ch_d     = CH_G;
              state_d  = ST_SETTLE;
            end
            CH_G: begin
              shad_g_d = edge_inc_s;
              ch_d     = CH_B;
              state_d  = ST_SETTLE;
            end
            default: begin
              // Publish now so the new values and valid appear together
              // during the CLASSIFY cycle.
              state_d = ST_CLASSIFY;
              red_d   = shad_r_q;
              green_d = shad_g_q;
              blue_d  = edge_inc_s;
              color_d = pick_color(shad_r_q, shad_g_q, edge_inc_s);
              valid_d = 1'b1;
            end
          endcase
        end else begin
          edge_cnt_d = edge_inc_s;
          cyc_d      = cyc_q + 32'd1;
        end
      end

      ST_CLASSIFY: begin
        if (en) begin
          state_d    = ST_SETTLE;
          ch_d       = CH_R;
          cyc_d      = 32'd0;
          edge_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Filter pins and busy follow the state being entered, so a channel change
  // and its filter change land on the same clock edge.
  always_comb begin
    filt_d = 2'b00;
    busy_d = 1'b0;
    if (state_d == ST_IDLE) begin
      filt_d = 2'b00;
      busy_d = 1'b0;
    end else begin
      filt_d = filt_of(ch_d);
      busy_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= CH_R;
      cyc_q      <= 32'd0;
      edge_cnt_q <= {CNT_W{1'b0}};
      shad_r_q   <= {CNT_W{1'b0}};
      shad_g_q   <= {CNT_W{1'b0}};
      red_q      <= {CNT_W{1'b0}};
      green_q    <= {CNT_W{1'b0}};
      blue_q     <= {CNT_W{1'b0}};
      color_q    <= 2'b00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      filt_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cyc_q      <= cyc_d;
      edge_cnt_q <= edge_cnt_d;
      shad_r_q   <= shad_r_d;
      shad_g_q   <= shad_g_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      color_q    <= color_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      filt_q     <= filt_d;
    end
  end

  assign s2        = filt_q[1];
  assign s3        = filt_q[0];
  assign red_cnt   = red_q;
  assign green_cnt = green_q;
  assign blue_cnt  = blue_q;
  assign color     = color_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_color_freq_sampler.sv
// Testbench for color_freq_sampler. A main instance (CNT_W=8) and a
// saturation instance (CNT_W=4, sensor period fixed at 4 clk) share en/rst.
// Expected frames are queued when a frame is launched; a monitor pops and
// compares whenever an instance pulses valid.
module tb_color_freq_sampler;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sensor_main;
  logic       sensor_sat;
  logic       s2, s3, valid, busy;
  logic [7:0] red_cnt, green_cnt, blue_cnt;
  logic [1:0] color;
  logic       s2_sat, s3_sat, valid_sat, busy_sat;
  logic [3:0] red_sat, green_sat, blue_sat;
  logic [1:0] color_sat;

  int checks = 0;
  int errors = 0;
  int per_r  = 4;
  int per_g  = 4;
  int per_b  = 4;
  int gcnt   = 0;

  typedef struct {
    int r_lo; int r_hi;
    int g_lo; int g_hi;
    int b_lo; int b_hi;
    int col;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];

  color_freq_sampler #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(8), .MIN_COUNT(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sensor_out(sensor_main),
    .s2(s2), .s3(s3), .red_cnt(red_cnt), .green_cnt(green_cnt),
    .blue_cnt(blue_cnt), .color(color), .valid(valid), .busy(busy)
  );

  color_freq_sampler #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(4), .MIN_COUNT(5)
  ) dut_sat (
    .clk(clk), .rst(rst), .en(en), .sensor_out(sensor_sat),
    .s2(s2_sat), .s3(s3_sat), .red_cnt(red_sat), .green_cnt(green_sat),
    .blue_cnt(blue_sat), .color(color_sat), .valid(valid_sat), .busy(busy_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sensor waveforms: free-running phase, period chosen by the filter pins.
  initial begin
    int p;
    sensor_main = 1'b0;
    sensor_sat  = 1'b0;
    forever begin
      @(negedge clk);
      gcnt++;
      case ({s2, s3})
        2'b00:   p = per_r;
        2'b11:   p = per_g;
        2'b01:   p = per_b;
        default: p = per_r;
      endcase
      sensor_main = ((gcnt % p) < (p / 2));
      sensor_sat  = ((gcnt % 4) < 2);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if ((act < lo) || (act > hi)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Monitor: compare every published frame against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (q_main.size() == 0) begin
          chk("unexpected_valid_main", 1, 0);
        end else begin
          e = q_main.pop_front();
          chk_rng("red_cnt", int'(red_cnt), e.r_lo, e.r_hi);
          chk_rng("green_cnt", int'(green_cnt), e.g_lo, e.g_hi);
          chk_rng("blue_cnt", int'(blue_cnt), e.b_lo, e.b_hi);
          chk("color", int'(color), e.col);
        end
      end
      if (valid_sat) begin
        if (q_sat.size() == 0) begin
          chk("unexpected_valid_sat", 1, 0);
        end else begin
          e = q_sat.pop_front();
          chk_rng("sat_red", int'(red_sat), e.r_lo, e.r_hi);
          chk_rng("sat_green", int'(green_sat), e.g_lo, e.g_hi);
          chk_rng("sat_blue", int'(blue_sat), e.b_lo, e.b_hi);
          chk("sat_color", int'(color_sat), e.col);
        end
      end
    end
  end

  // Launch one full frame, check its timing and filter sequence, then stop.
  task automatic run_frame(input int pr, input int pg, input int pb, input exp_t e);
    exp_t es;
    int   n;
    bit   seen;
    es = '{15, 15, 15, 15, 15, 15, 0};
    per_r = pr;
    per_g = pg;
    per_b = pb;
    q_main.push_back(e);
    q_sat.push_back(es);
    en   = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && (n < 400)) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("busy_first_settle", int'(busy), 1);
        chk("filt_red", int'({s2, s3}), 0);
      end
      if (n == 111) chk("filt_green", int'({s2, s3}), 3);
      if (n == 221) chk("filt_blue", int'({s2, s3}), 1);
      if (valid) seen = 1'b1;
    end
    chk("valid_latency", n, 331);
    @(negedge clk);
    chk("b2b_filt_red", int'({s2, s3}), 0);
    chk("b2b_busy", int'(busy), 1);
    chk("valid_one_cycle", int'(valid), 0);
    en = 1'b0;
    @(negedge clk);
    chk("busy_after_stop", int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_filt", int'({s2, s3}), 0);
    chk("rst_red", int'(red_cnt), 0);
    chk("rst_green", int'(green_cnt), 0);
    chk("rst_blue", int'(blue_cnt), 0);
    chk("rst_color", int'(color), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Red, green and blue dominant frames.
    run_frame(4, 20, 20, '{25, 25, 5, 5, 5, 5, 1});
    run_frame(20, 4, 20, '{5, 5, 25, 25, 5, 5, 2});
    run_frame(20, 20, 4, '{5, 5, 5, 5, 25, 25, 3});
    // Dark: all below threshold.
    run_frame(40, 40, 40, '{2, 3, 2, 3, 2, 3, 0});
    // Exact tie above threshold.
    run_frame(20, 20, 20, '{5, 5, 5, 5, 5, 5, 0});
    // Strict winner but under threshold.
    run_frame(40, 100, 100, '{2, 3, 1, 1, 1, 1, 0});
    // Winner exactly at threshold.
    run_frame(20, 100, 100, '{5, 5, 1, 1, 1, 1, 1});

    // Abort mid-GATE of green: published outputs must hold the last frame.
    per_r = 4;
    per_g = 20;
    per_b = 20;
    en = 1'b1;
    repeat (151) @(negedge clk);
    chk("abort_in_green", int'({s2, s3}), 3);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_filt", int'({s2, s3}), 0);
    chk("abort_red", int'(red_cnt), 5);
    chk("abort_green", int'(green_cnt), 1);
    chk("abort_blue", int'(blue_cnt), 1);
    chk("abort_color", int'(color), 1);
    repeat (5) @(negedge clk);
    run_frame(4, 20, 20, '{25, 25, 5, 5, 5, 5, 1});

    // Reset landing on the edge that would enter CLASSIFY.
    en = 1'b1;
    repeat (330) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", int'(valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_filt", int'({s2, s3}), 0);
    chk("mrst_red", int'(red_cnt), 0);
    chk("mrst_green", int'(green_cnt), 0);
    chk("mrst_blue", int'(blue_cnt), 0);
    chk("mrst_color", int'(color), 0);
    chk("mrst_sat_red", int'(red_sat), 0);
    rst = 1'b0;
    en  = 1'b0;
    repeat (5) @(negedge clk);

    chk("main_queue_empty", q_main.size(), 0);
    chk("sat_queue_empty", q_sat.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
